// File: rtl/mux_pkg.sv
// Shared select encoding for the 4:1 lane selector.
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_L0 = 2'd0;
    localparam sel_t SEL_L1 = 2'd1;
    localparam sel_t SEL_L2 = 2'd2;
    localparam sel_t SEL_L3 = 2'd3;

endpackage : mux_pkg

// File: rtl/mux4_core.sv
// Purely combinational 4:1 lane selector; an unknown select propagates X.
module mux4_core
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [4*WIDTH-1:0] I,
    input  sel_t               S,
    output logic [WIDTH-1:0]   Y
);

    // Route the selected lane to the output.
    always_comb begin
        Y = 'x;
        case (S)
            SEL_L0:  Y = I[0*WIDTH +: WIDTH];
            SEL_L1:  Y = I[1*WIDTH +: WIDTH];
            SEL_L2:  Y = I[2*WIDTH +: WIDTH];
            SEL_L3:  Y = I[3*WIDTH +: WIDTH];
            default: Y = 'x;
        endcase
    end

endmodule : mux4_core

// File: rtl/mux4to1_registered.sv
// 4:1 lane selector with a combinational output and a registered, valid-qualified copy.
module mux4to1_registered
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] I,
    input  sel_t               S,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   Y,
    output logic [WIDTH-1:0]   Y_q,
    output logic               out_valid
);

    logic [WIDTH-1:0] sel_lane;

    mux4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .I (I),
        .S (S),
        .Y (sel_lane)
    );

    assign Y = sel_lane;

    // Capture the selected lane when qualified; the data holds otherwise, valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_q       <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            Y_q       <= sel_lane;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule : mux4to1_registered

// File: tb/tb_mux4to1_registered.sv
// Directed bench for mux4to1_registered: WIDTH=1 and WIDTH=8 instances, scoreboarded register path.
module tb_mux4to1_registered;

    logic       clk;
    logic       rst;
    logic [3:0] i1;
    logic [1:0] s1;
    logic       iv1;
    logic       y1;
    logic       yq1;
    logic       ov1;

    logic [31:0] i8;
    logic [1:0]  s8;
    logic        iv8;
    logic [7:0]  y8;
    logic [7:0]  yq8;
    logic        ov8;

    int tests = 0;
    int fails = 0;

    // Expected {Y_q, out_valid} per edge, pushed when stimulus is driven.
    logic [1:0] sb_q[$];
    logic       model_yq;

    mux4to1_registered #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .I         (i1),
        .S         (s1),
        .in_valid  (iv1),
        .Y         (y1),
        .Y_q       (yq1),
        .out_valid (ov1)
    );

    mux4to1_registered #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .I         (i8),
        .S         (s8),
        .in_valid  (iv8),
        .Y         (y8),
        .Y_q       (yq8),
        .out_valid (ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic lane1(input logic [3:0] v, input logic [1:0] s);
        return v[s];
    endfunction

    // Drive one cycle of WIDTH=1 stimulus at the falling edge, then check after the rising edge.
    task automatic step(input string tag, input logic [3:0] iv, input logic [1:0] sv, input logic vld);
        logic [1:0] got;
        @(negedge clk);
        i1  = iv;
        s1  = sv;
        iv1 = vld;
        if (vld) model_yq = lane1(iv, sv);
        sb_q.push_back({model_yq, vld});
        #1;
        chk({tag, "_comb"}, 8'(y1), 8'(lane1(iv, sv)));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_yq"}, 8'(yq1), 8'(got[1]));
            chk({tag, "_ov"}, 8'(ov1), 8'(got[0]));
        end
    endtask

    initial begin
        rst      = 1'b1;
        i1       = 4'b1111;
        s1       = 2'd0;
        iv1      = 1'b0;
        i8       = 32'hDDCC_BBAA;
        s8       = 2'd0;
        iv8      = 1'b0;
        model_yq = 1'b0;

        // Reset init: registered path cleared, comb path live.
        #2;
        chk("rst_yq", 8'(yq1), 8'd0);
        chk("rst_ov", 8'(ov1), 8'd0);
        chk("rst_y", 8'(y1), 8'd1);

        // Exhaustive comb sweep under reset: Y must ignore rst.
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < 4; s++) begin
                i1 = 4'(i);
                s1 = 2'(s);
                #10;
                chk($sformatf("sweep_i%0d_s%0d", i, s), 8'(y1), 8'(lane1(4'(i), 2'(s))));
            end
        end
        chk("sweep_rst_yq", 8'(yq1), 8'd0);

        // Release reset with a capture pending.
        @(negedge clk);
        rst = 1'b0;
        step("release", 4'b1111, 2'd0, 1'b1);

        // Latency: exactly one edge from capture to Y_q.
        step("lat_n", 4'b0010, 2'd1, 1'b1);
        step("lat_n1", 4'b0000, 2'd1, 1'b1);

        // in_valid low holds data and drops valid.
        step("iv_cap", 4'b1000, 2'd3, 1'b1);
        step("iv_low", 4'b0000, 2'd3, 1'b0);
        step("iv_low2", 4'b1111, 2'd2, 1'b0);

        // Async reset between edges clears immediately.
        step("pre_rst", 4'b1000, 2'd3, 1'b1);
        @(negedge clk);
        iv1 = 1'b1;
        i1  = 4'b1111;
        #1;
        rst = 1'b1;
        #1;
        chk("async_yq", 8'(yq1), 8'd0);
        chk("async_ov", 8'(ov1), 8'd0);
        model_yq = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_yq", 8'(yq1), 8'd0);
        chk("rst_hold_ov", 8'(ov1), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 4'b0100, 2'd2, 1'b1);
        step("post_rst_idle", 4'b0000, 2'd0, 1'b0);

        // WIDTH=8 lane check, comb and registered.
        for (int s = 0; s < 4; s++) begin
            logic [7:0] exp8;
            @(negedge clk);
            s8   = 2'(s);
            iv8  = 1'b1;
            exp8 = 8'hAA + 8'(s * 8'h11);
            #1;
            chk($sformatf("w8_y_s%0d", s), y8, exp8);
            @(posedge clk);
            #1;
            chk($sformatf("w8_yq_s%0d", s), yq8, exp8);
            chk($sformatf("w8_ov_s%0d", s), 8'(ov8), 8'd1);
        end
        @(negedge clk);
        iv8 = 1'b0;
        s8  = 2'd0;
        @(posedge clk);
        #1;
        chk("w8_hold_yq", yq8, 8'hDD);
        chk("w8_hold_ov", 8'(ov8), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mux4to1_registered
